// File: rtl/ctr_unit.sv
// ctr_unit: main decoder of the single-cycle MIPS CPU.
// Ports: clk, rst_n (sync, active-low); op/func instruction fields in;
// datapath strobes, class flags, 4-bit aluop out (combinational);
// halt out (registered, sticky after syscall).
module ctr_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] func,
    output logic       regwrite,
    output logic       regdst,
    output logic       memread,
    output logic       memwrite,
    output logic       memtoreg,
    output logic       alusrc,
    output logic       branch,
    output logic       bneorbeq,
    output logic       jump,
    output logic       isjal,
    output logic       isjr,
    output logic       issyscall,
    output logic       isshamt,
    output logic       iscop0,
    output logic       zeroextend,
    output logic       readrs,
    output logic       readrt,
    output logic [3:0] aluop,
    output logic       halt
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_COP0  = 6'b010000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL     = 6'b000000;
    localparam logic [5:0] FN_SRL     = 6'b000010;
    localparam logic [5:0] FN_SRA     = 6'b000011;
    localparam logic [5:0] FN_SLLV    = 6'b000100;
    localparam logic [5:0] FN_SRLV    = 6'b000110;
    localparam logic [5:0] FN_SRAV    = 6'b000111;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_SYSCALL = 6'b001100;
    localparam logic [5:0] FN_ADD     = 6'b100000;
    localparam logic [5:0] FN_ADDU    = 6'b100001;
    localparam logic [5:0] FN_SUB     = 6'b100010;
    localparam logic [5:0] FN_SUBU    = 6'b100011;
    localparam logic [5:0] FN_AND     = 6'b100100;
    localparam logic [5:0] FN_OR      = 6'b100101;
    localparam logic [5:0] FN_XOR     = 6'b100110;
    localparam logic [5:0] FN_NOR     = 6'b100111;
    localparam logic [5:0] FN_SLT     = 6'b101010;
    localparam logic [5:0] FN_SLTU    = 6'b101011;

    localparam logic [3:0] ALU_SLL  = 4'd0;
    localparam logic [3:0] ALU_SRA  = 4'd1;
    localparam logic [3:0] ALU_SRL  = 4'd2;
    localparam logic [3:0] ALU_ADD  = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_XOR  = 4'd9;
    localparam logic [3:0] ALU_NOR  = 4'd10;
    localparam logic [3:0] ALU_SLT  = 4'd11;
    localparam logic [3:0] ALU_SLTU = 4'd12;

    logic       w_regwrite;
    logic       w_regdst;
    logic       w_memread;
    logic       w_memwrite;
    logic       w_memtoreg;
    logic       w_alusrc;
    logic       w_branch;
    logic       w_bneorbeq;
    logic       w_jump;
    logic       w_isjal;
    logic       w_isjr;
    logic       w_issyscall;
    logic       w_isshamt;
    logic       w_iscop0;
    logic       w_zeroextend;
    logic       w_readrs;
    logic       w_readrt;
    logic [3:0] w_aluop;
    // R-type ALU/shift group shares regdst/regwrite/readrt
    logic       w_ralu;
    logic       r_halt;

    always_comb begin
        w_regwrite   = 1'b0;
        w_regdst     = 1'b0;
        w_memread    = 1'b0;
        w_memwrite   = 1'b0;
        w_memtoreg   = 1'b0;
        w_alusrc     = 1'b0;
        w_branch     = 1'b0;
        w_bneorbeq   = 1'b0;
        w_jump       = 1'b0;
        w_isjal      = 1'b0;
        w_isjr       = 1'b0;
        w_issyscall  = 1'b0;
        w_isshamt    = 1'b0;
        w_iscop0     = 1'b0;
        w_zeroextend = 1'b0;
        w_readrs     = 1'b0;
        w_readrt     = 1'b0;
        w_aluop      = ALU_SLL;
        w_ralu       = 1'b0;

        case (op)
            OP_RTYPE: begin
                // func is only examined here, so junk on func
                // under any other opcode cannot reach the outputs
                case (func)
                    FN_SLL: begin
                        w_ralu    = 1'b1;
                        w_isshamt = 1'b1;
                        w_aluop   = ALU_SLL;
                    end
                    FN_SRA: begin
                        w_ralu    = 1'b1;
                        w_isshamt = 1'b1;
                        w_aluop   = ALU_SRA;
                    end
                    FN_SRL: begin
                        w_ralu    = 1'b1;
                        w_isshamt = 1'b1;
                        w_aluop   = ALU_SRL;
                    end
                    FN_SLLV: begin
                        w_ralu  = 1'b1;
                        w_aluop = ALU_SLL;
                    end
                    FN_SRAV: begin
                        w_ralu  = 1'b1;
                        w_aluop = ALU_SRA;
                    end
                    FN_SRLV: begin
                        w_ralu  = 1'b1;
                        w_aluop = ALU_SRL;
                    end
                    FN_ADD, FN_ADDU: begin
                        w_ralu  = 1'b1;
                        w_aluop = ALU_ADD;
                    end
                    FN_SUB, FN_SUBU: begin
                        w_ralu  = 1'b1;
                        w_aluop = ALU_SUB;
                    end
                    FN_AND: begin
                        w_ralu  = 1'b1;
                        w_aluop = ALU_AND;
                    end
                    FN_OR: begin
                        w_ralu  = 1'b1;
                        w_aluop = ALU_OR;
                    end
                    FN_XOR: begin
                        w_ralu  = 1'b1;
                        w_aluop = ALU_XOR;
                    end
                    FN_NOR: begin
                        w_ralu  = 1'b1;
                        w_aluop = ALU_NOR;
                    end
                    FN_SLT: begin
                        w_ralu  = 1'b1;
                        w_aluop = ALU_SLT;
                    end
                    FN_SLTU: begin
                        w_ralu  = 1'b1;
                        w_aluop = ALU_SLTU;
                    end
                    FN_JR: begin
                        w_jump   = 1'b1;
                        w_isjr   = 1'b1;
                        w_readrs = 1'b1;
                    end
                    FN_SYSCALL: begin
                        // datapath swaps in $v0/$a0 as rs/rt
                        w_issyscall = 1'b1;
                        w_readrs    = 1'b1;
                        w_readrt    = 1'b1;
                    end
                    default: ;
                endcase
                if (w_ralu) begin
                    w_regdst   = 1'b1;
                    w_regwrite = 1'b1;
                    w_readrt   = 1'b1;
                    // shamt shifts take the amount from the
                    // instruction, not from rs
                    w_readrs   = ~w_isshamt;
                end
            end
            OP_ADDI, OP_ADDIU: begin
                w_alusrc   = 1'b1;
                w_regwrite = 1'b1;
                w_readrs   = 1'b1;
                w_aluop    = ALU_ADD;
            end
            OP_SLTI: begin
                w_alusrc   = 1'b1;
                w_regwrite = 1'b1;
                w_readrs   = 1'b1;
                w_aluop    = ALU_SLT;
            end
            OP_SLTIU: begin
                w_alusrc   = 1'b1;
                w_regwrite = 1'b1;
                w_readrs   = 1'b1;
                w_aluop    = ALU_SLTU;
            end
            OP_ANDI: begin
                w_alusrc     = 1'b1;
                w_regwrite   = 1'b1;
                w_readrs     = 1'b1;
                w_zeroextend = 1'b1;
                w_aluop      = ALU_AND;
            end
            OP_ORI: begin
                w_alusrc     = 1'b1;
                w_regwrite   = 1'b1;
                w_readrs     = 1'b1;
                w_zeroextend = 1'b1;
                w_aluop      = ALU_OR;
            end
            OP_XORI: begin
                w_alusrc     = 1'b1;
                w_regwrite   = 1'b1;
                w_readrs     = 1'b1;
                w_zeroextend = 1'b1;
                w_aluop      = ALU_XOR;
            end
            OP_LW: begin
                w_memread  = 1'b1;
                w_memtoreg = 1'b1;
                w_alusrc   = 1'b1;
                w_regwrite = 1'b1;
                w_readrs   = 1'b1;
                w_aluop    = ALU_ADD;
            end
            OP_SW: begin
                w_memwrite = 1'b1;
                w_alusrc   = 1'b1;
                w_readrs   = 1'b1;
                w_readrt   = 1'b1;
                w_aluop    = ALU_ADD;
            end
            OP_BEQ, OP_BNE: begin
                w_branch   = 1'b1;
                w_bneorbeq = op[0];
                w_readrs   = 1'b1;
                w_readrt   = 1'b1;
                w_aluop    = ALU_SUB;
            end
            OP_J: begin
                w_jump = 1'b1;
            end
            OP_JAL: begin
                // datapath supplies $31 and PC+4
                w_jump     = 1'b1;
                w_isjal    = 1'b1;
                w_regwrite = 1'b1;
            end
            OP_COP0: begin
                // mfc0/mtc0 split happens downstream on rs
                w_iscop0 = 1'b1;
                w_readrt = 1'b1;
            end
            default: ;
        endcase
    end

    // Sticky halt: reset wins over a simultaneous syscall
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_halt <= 1'b0;
        end else if (w_issyscall) begin
            r_halt <= 1'b1;
        end
    end

    assign regwrite   = w_regwrite;
    assign regdst     = w_regdst;
    assign memread    = w_memread;
    assign memwrite   = w_memwrite;
    assign memtoreg   = w_memtoreg;
    assign alusrc     = w_alusrc;
    assign branch     = w_branch;
    assign bneorbeq   = w_bneorbeq;
    assign jump       = w_jump;
    assign isjal      = w_isjal;
    assign isjr       = w_isjr;
    assign issyscall  = w_issyscall;
    assign isshamt    = w_isshamt;
    assign iscop0     = w_iscop0;
    assign zeroextend = w_zeroextend;
    assign readrs     = w_readrs;
    assign readrt     = w_readrt;
    assign aluop      = w_aluop;
    assign halt       = r_halt;

endmodule

// File: tb/tb_ctr_unit.sv
// tb_ctr_unit: directed + random checks of ctr_unit against
// a table-driven instruction model and a sticky-halt model.
module tb_ctr_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] func;
    logic       regwrite, regdst, memread, memwrite, memtoreg, alusrc;
    logic       branch, bneorbeq, jump, isjal, isjr, issyscall;
    logic       isshamt, iscop0, zeroextend, readrs, readrt;
    logic [3:0] aluop;
    logic       halt;

    always #5 clk = ~clk;

    ctr_unit dut (
        .clk(clk), .rst_n(rst_n), .op(op), .func(func),
        .regwrite(regwrite), .regdst(regdst), .memread(memread),
        .memwrite(memwrite), .memtoreg(memtoreg), .alusrc(alusrc),
        .branch(branch), .bneorbeq(bneorbeq), .jump(jump),
        .isjal(isjal), .isjr(isjr), .issyscall(issyscall),
        .isshamt(isshamt), .iscop0(iscop0), .zeroextend(zeroextend),
        .readrs(readrs), .readrt(readrt), .aluop(aluop), .halt(halt)
    );

    // Flag one-hots, packed above a 4-bit aluop field
    localparam logic [16:0] RW = 17'h10000;
    localparam logic [16:0] RD = 17'h08000;
    localparam logic [16:0] MR = 17'h04000;
    localparam logic [16:0] MW = 17'h02000;
    localparam logic [16:0] MT = 17'h01000;
    localparam logic [16:0] AS = 17'h00800;
    localparam logic [16:0] BR = 17'h00400;
    localparam logic [16:0] BN = 17'h00200;
    localparam logic [16:0] JP = 17'h00100;
    localparam logic [16:0] JL = 17'h00080;
    localparam logic [16:0] JR = 17'h00040;
    localparam logic [16:0] SC = 17'h00020;
    localparam logic [16:0] SH = 17'h00010;
    localparam logic [16:0] C0 = 17'h00008;
    localparam logic [16:0] ZE = 17'h00004;
    localparam logic [16:0] RS = 17'h00002;
    localparam logic [16:0] RT = 17'h00001;

    logic [20:0] optbl [64];
    logic [20:0] fntbl [64];
    logic        m_halt;
    int          nvec = 0;
    int          nerr = 0;

    int defops [15] = '{0, 2, 3, 4, 5, 8, 9, 10, 11, 12, 13, 14, 16, 35, 43};
    int deffns [20] = '{0, 2, 3, 4, 6, 7, 8, 12, 32, 33, 34, 35,
                        36, 37, 38, 39, 42, 43, 1, 63};

    function automatic logic [20:0] row(input logic [16:0] f,
                                        input int a);
        return {f, a[3:0]};
    endfunction

    function automatic logic [20:0] model(input logic [5:0] o,
                                          input logic [5:0] f);
        return (o == 6'd0) ? fntbl[f] : optbl[o];
    endfunction

    function automatic logic [20:0] observed();
        return {regwrite, regdst, memread, memwrite, memtoreg, alusrc,
                branch, bneorbeq, jump, isjal, isjr, issyscall,
                isshamt, iscop0, zeroextend, readrs, readrt, aluop};
    endfunction

    task automatic step(input logic [5:0] o, input logic [5:0] f,
                        input logic r, input string tag);
        logic [20:0] e;
        op = o;
        func = f;
        rst_n = r;
        #1;
        e = model(o, f);
        nvec++;
        assert (observed() === e) else begin
            nerr++;
            $error("FAIL %s op=%b func=%b got=%h exp=%h",
                   tag, o, f, observed(), e);
        end
        @(posedge clk);
        if (!r) m_halt = 1'b0;
        else if (e[9]) m_halt = 1'b1;
        #1;
        nvec++;
        assert (halt === m_halt) else begin
            nerr++;
            $error("FAIL %s_halt got=%b exp=%b", tag, halt, m_halt);
        end
    endtask

    initial begin
        logic [20:0] rtype;
        for (int i = 0; i < 64; i++) begin
            optbl[i] = '0;
            fntbl[i] = '0;
        end
        rtype = row(RW | RD | RS | RT, 0);
        fntbl[6'b100000] = rtype | 21'd5;
        fntbl[6'b100001] = rtype | 21'd5;
        fntbl[6'b100010] = rtype | 21'd6;
        fntbl[6'b100011] = rtype | 21'd6;
        fntbl[6'b100100] = rtype | 21'd7;
        fntbl[6'b100101] = rtype | 21'd8;
        fntbl[6'b100110] = rtype | 21'd9;
        fntbl[6'b100111] = rtype | 21'd10;
        fntbl[6'b101010] = rtype | 21'd11;
        fntbl[6'b101011] = rtype | 21'd12;
        fntbl[6'b000000] = row(RW | RD | RT | SH, 0);
        fntbl[6'b000011] = row(RW | RD | RT | SH, 1);
        fntbl[6'b000010] = row(RW | RD | RT | SH, 2);
        fntbl[6'b000100] = rtype | 21'd0;
        fntbl[6'b000111] = rtype | 21'd1;
        fntbl[6'b000110] = rtype | 21'd2;
        fntbl[6'b001000] = row(JP | JR | RS, 0);
        fntbl[6'b001100] = row(SC | RS | RT, 0);
        optbl[6'b001000] = row(AS | RW | RS, 5);
        optbl[6'b001001] = row(AS | RW | RS, 5);
        optbl[6'b001010] = row(AS | RW | RS, 11);
        optbl[6'b001011] = row(AS | RW | RS, 12);
        optbl[6'b001100] = row(AS | RW | RS | ZE, 7);
        optbl[6'b001101] = row(AS | RW | RS | ZE, 8);
        optbl[6'b001110] = row(AS | RW | RS | ZE, 9);
        optbl[6'b100011] = row(MR | MT | AS | RW | RS, 5);
        optbl[6'b101011] = row(MW | AS | RS | RT, 5);
        optbl[6'b000100] = row(BR | RS | RT, 6);
        optbl[6'b000101] = row(BR | BN | RS | RT, 6);
        optbl[6'b000010] = row(JP, 0);
        optbl[6'b000011] = row(JP | JL | RW, 0);
        optbl[6'b010000] = row(C0 | RT, 0);

        m_halt = 1'b0;
        op = '0;
        func = '0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;

        step(6'b000000, 6'b100000, 1'b0, "reset_add");
        step(6'b100011, 6'b000000, 1'b1, "lw");
        step(6'b101011, 6'b111111, 1'b1, "sw");
        step(6'b000000, 6'b100000, 1'b1, "add");
        step(6'b000000, 6'b100010, 1'b1, "sub");
        step(6'b000000, 6'b100100, 1'b1, "and");
        step(6'b000000, 6'b100101, 1'b1, "or");
        step(6'b000000, 6'b000000, 1'b1, "sll");
        step(6'b000000, 6'b000111, 1'b1, "srav");
        step(6'b000000, 6'b001000, 1'b1, "jr");
        step(6'b000100, 6'b001100, 1'b1, "beq");
        step(6'b000101, 6'b001100, 1'b1, "bne");
        step(6'b000010, 6'b001100, 1'b1, "j");
        step(6'b000011, 6'b001100, 1'b1, "jal");
        step(6'b001100, 6'b001100, 1'b1, "andi");
        step(6'b001101, 6'b001100, 1'b1, "ori");
        step(6'b001000, 6'b001100, 1'b1, "addi");
        step(6'b010000, 6'b001100, 1'b1, "cop0");
        step(6'b111111, 6'b001100, 1'b1, "undef_op");
        step(6'b000000, 6'b111111, 1'b1, "undef_fn");
        step(6'b000000, 6'b001100, 1'b1, "syscall");
        step(6'b100011, 6'b001100, 1'b1, "sticky1");
        step(6'b000000, 6'b100000, 1'b1, "sticky2");
        step(6'b000000, 6'b100000, 1'b0, "rst_clear");
        step(6'b000000, 6'b001100, 1'b0, "rst_vs_sys");
        step(6'b000000, 6'b001100, 1'b1, "sys_again");

        for (int k = 0; k < 400; k++) begin
            logic [5:0] o, f;
            logic r;
            o = ($urandom_range(9, 0) < 8)
                ? 6'(defops[$urandom_range(14, 0)])
                : 6'($urandom);
            if (o == 6'd0 && $urandom_range(1, 0) == 1) o = 6'd0;
            f = ($urandom_range(9, 0) < 8)
                ? 6'(deffns[$urandom_range(19, 0)])
                : 6'($urandom);
            r = ($urandom_range(24, 0) != 0);
            step(o, f, r, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
